alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 143 ++++++++++++++
 tb/tb_alu_issue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Two-stage issue/writeback wrapper around a combinational ALU: an issue register (E)
// feeds the ALU, a result register (W) holds the captured result, and the flag register sits between them.
module alu_issue (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [3:0]  in_dst,
   input  logic        in_setflags,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [7:0]  alu_op,
   output logic        alu_carry_in,
   input  logic [31:0] alu_c,
   input  logic        alu_carry,
   input  logic        alu_zero,
   input  logic        alu_neg,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_dst,
   output logic        flag_c,
   output logic        flag_z,
   output logic        flag_n,
   output logic [15:0] retire_count
);

   logic        e_valid_r;
   logic [7:0]  e_op_r;
   logic [31:0] e_a_r;
   logic [31:0] e_b_r;
   logic [3:0]  e_dst_r;
   logic        e_setflags_r;

   logic        w_valid_r;
   logic [31:0] w_result_r;
   logic [3:0]  w_dst_r;

   logic        flag_c_r;
   logic        flag_z_r;
   logic        flag_n_r;
   logic [15:0] retire_count_r;

   logic        w_free_s;
   logic        e_adv_s;
   logic        in_ready_s;
   logic        accept_s;
   logic        retire_s;

   // Handshake: E drains into W whenever W is empty or being consumed this cycle.
   always_comb begin
      w_free_s   = ~w_valid_r | out_ready;
      e_adv_s    = e_valid_r & w_free_s;
      in_ready_s = ~e_valid_r | e_adv_s;
      accept_s   = in_valid & in_ready_s;
      retire_s   = w_valid_r & out_ready;
   end

   // Issue register: an accepted op overrides the clear caused by E advancing.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_valid_r    <= 1'b0;
         e_op_r       <= 8'd0;
         e_a_r        <= 32'd0;
         e_b_r        <= 32'd0;
         e_dst_r      <= 4'd0;
         e_setflags_r <= 1'b0;
      end else if (accept_s) begin
         e_valid_r    <= 1'b1;
         e_op_r       <= in_op;
         e_a_r        <= in_a;
         e_b_r        <= in_b;
         e_dst_r      <= in_dst;
         e_setflags_r <= in_setflags;
      end else if (e_adv_s) begin
         e_valid_r    <= 1'b0;
      end else begin
         e_valid_r    <= e_valid_r;
      end
   end

   // Result register: capture the ALU output as E advances, release once consumed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_valid_r  <= 1'b0;
         w_result_r <= 32'd0;
         w_dst_r    <= 4'd0;
      end else if (e_adv_s) begin
         w_valid_r  <= 1'b1;
         w_result_r <= alu_c;
         w_dst_r    <= e_dst_r;
      end else if (retire_s) begin
         w_valid_r  <= 1'b0;
      end else begin
         w_valid_r  <= w_valid_r;
      end
   end

   // Flag register: written at the same edge the next op enters E, so adc/sbc chains see fresh carry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         flag_c_r <= 1'b0;
         flag_z_r <= 1'b0;
         flag_n_r <= 1'b0;
      end else if (e_adv_s && e_setflags_r) begin
         flag_c_r <= alu_carry;
         flag_z_r <= alu_zero;
         flag_n_r <= alu_neg;
      end else begin
         flag_c_r <= flag_c_r;
         flag_z_r <= flag_z_r;
         flag_n_r <= flag_n_r;
      end
   end

   // Retire counter, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         retire_count_r <= 16'd0;
      end else if (retire_s) begin
         retire_count_r <= retire_count_r + 16'd1;
      end else begin
         retire_count_r <= retire_count_r;
      end
   end

   assign in_ready     = in_ready_s;
   assign alu_a        = e_a_r;
   assign alu_b        = e_b_r;
   assign alu_op       = e_op_r;
   assign alu_carry_in = flag_c_r;
   assign out_valid    = w_valid_r;
   assign out_result   = w_result_r;
   assign out_dst      = w_dst_r;
   assign flag_c       = flag_c_r;
   assign flag_z       = flag_z_r;
   assign flag_n       = flag_n_r;
   assign retire_count = retire_count_r;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: the bench plays the ALU and keeps an in-order
// reference model (queue of expected results, running flags, retire count).
module tb_alu_issue;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_dst;
   logic        in_setflags;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [7:0]  alu_op;
   logic        alu_carry_in;
   logic [31:0] alu_c;
   logic        alu_carry;
   logic        alu_zero;
   logic        alu_neg;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_dst;
   logic        flag_c;
   logic        flag_z;
   logic        flag_n;
   logic [15:0] retire_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [35:0] exp_q[$];
   logic        m_c, m_z, m_n;
   logic [15:0] m_ret;

   localparam logic [7:0] OP_ADD = 8'd0, OP_ADC = 8'd1, OP_SUB = 8'd2, OP_SBC = 8'd3,
                          OP_OR = 8'd4, OP_AND = 8'd5, OP_NOT = 8'd6, OP_XOR = 8'd7,
                          OP_CMP = 8'd8, OP_SHL = 8'd12, OP_SHR = 8'd13;

   alu_issue dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .in_dst(in_dst), .in_setflags(in_setflags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
      .alu_c(alu_c), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dst(out_dst),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU behaviour: returns {carry, zero, neg, result}; carry means borrow for subtracts.
   function automatic logic [34:0] alu_ref(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
      logic [32:0] s;
      logic [31:0] c;
      logic        cy;
      cy = 1'b0;
      case (op)
         OP_ADD:  begin s = {1'b0, a} + {1'b0, b};                c = s[31:0]; cy = s[32]; end
         OP_ADC:  begin s = {1'b0, a} + {1'b0, b} + {32'd0, cin}; c = s[31:0]; cy = s[32]; end
         OP_SUB:  begin s = {1'b0, a} - {1'b0, b};                c = s[31:0]; cy = s[32]; end
         OP_SBC:  begin s = {1'b0, a} - {1'b0, b} - {32'd0, cin}; c = s[31:0]; cy = s[32]; end
         OP_OR:   c = a | b;
         OP_AND:  c = a & b;
         OP_NOT:  c = ~a;
         OP_XOR:  c = a ^ b;
         OP_CMP:  begin c = (a < b) ? 32'hFFFFFFFF : ((a == b) ? 32'd0 : 32'd1); cy = (a < b); end
         OP_SHL:  c = a << b[4:0];
         OP_SHR:  c = a >> b[4:0];
         default: c = 32'd0;
      endcase
      return {cy, (c == 32'd0), c[31], c};
   endfunction

   assign {alu_carry, alu_zero, alu_neg, alu_c} = alu_ref(alu_op, alu_a, alu_b, alu_carry_in);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] dst, input logic sf,
                        input logic ordy);
      in_valid = v; in_op = op; in_a = a; in_b = b; in_dst = dst; in_setflags = sf;
      out_ready = ordy;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
      m_ret = 16'd0;
   endtask

   // One clock: check handshake/result against the model, update model, advance to next negedge.
   task automatic tick();
      logic [35:0] e;
      logic [34:0] r;
      logic        exp_ready;
      #1;
      exp_ready = (exp_q.size() < 2) || out_ready;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (exp_q.size() == 0) check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("out_result", out_result, e[31:0]);
         check("out_dst", {28'd0, out_dst}, {28'd0, e[35:32]});
         m_ret = m_ret + 16'd1;
      end
      if (in_valid && exp_ready) begin
         r = alu_ref(in_op, in_a, in_b, m_c);
         exp_q.push_back({in_dst, r[31:0]});
         if (in_setflags) {m_c, m_z, m_n} = r[34:32];
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive(1'b0, 8'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
      repeat (n) tick();
   endtask

   task automatic quiesce();
      idle(3);
      check("q_out_valid", {31'd0, out_valid}, 32'd0);
      check("q_flags", {29'd0, flag_c, flag_z, flag_n}, {29'd0, m_c, m_z, m_n});
      check("q_retire", {16'd0, retire_count}, {16'd0, m_ret});
   endtask

   task automatic random_op(input logic v, input logic ordy);
      logic [7:0] ops[13];
      logic [31:0] a, b;
      ops = '{OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_OR, OP_AND, OP_NOT, OP_XOR, OP_CMP,
              OP_SHL, OP_SHR, 8'd9, 8'hFF};
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(v, ops[$urandom_range(0, 12)], a, b, 4'($urandom), 1'($urandom), ordy);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      logic sc, sz, sn;
      drive(1'b0, 8'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
      resetn = 1'b0;
      model_reset();
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_dst", {28'd0, out_dst}, 32'd0);
      check("rst_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
      check("rst_retire", {16'd0, retire_count}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Carry out of add feeds the next adc.
      drive(1'b1, OP_ADD, 32'hFFFFFFFF, 32'd1, 4'd3, 1'b1, 1'b1);
      tick();
      check("lat_e_only", {31'd0, out_valid}, 32'd0);
      drive(1'b1, OP_ADC, 32'd0, 32'd0, 4'd4, 1'b1, 1'b1);
      tick();
      check("add_valid", {31'd0, out_valid}, 32'd1);
      check("add_result", out_result, 32'd0);
      check("add_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b100 | 32'b010);
      idle(1);
      check("adc_result", out_result, 32'd1);
      quiesce();

      // Compare results and flags.
      drive(1'b1, OP_CMP, 32'd3, 32'd5, 4'd1, 1'b1, 1'b1);
      tick();
      idle(1);
      check("cmp_lt_result", out_result, 32'hFFFFFFFF);
      check("cmp_lt_c", {31'd0, flag_c}, 32'd1);
      check("cmp_lt_n", {31'd0, flag_n}, 32'd1);
      drive(1'b1, OP_CMP, 32'd5, 32'd5, 4'd2, 1'b1, 1'b1);
      tick();
      idle(1);
      check("cmp_eq_result", out_result, 32'd0);
      check("cmp_eq_z", {31'd0, flag_z}, 32'd1);
      quiesce();

      // Backpressure: only two ops in flight, W holds still, then in-order drain.
      drive(1'b1, OP_ADD, 32'd10, 32'd20, 4'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd6, 1'b0, 1'b0);
      tick();
      drive(1'b1, OP_SUB, 32'd7, 32'd9, 4'd7, 1'b1, 1'b0);
      repeat (3) begin
         tick();
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold", out_result, 32'd30);
      end
      out_ready = 1'b1;
      tick();
      drive(1'b0, 8'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
      check("bp_drain1", {31'd0, out_valid}, 32'd1);
      tick();
      check("bp_drain2", {31'd0, out_valid}, 32'd1);
      quiesce();

      // Back-to-back after reset: first adc sees carry 0.
      do_reset();
      @(negedge clk);
      drive(1'b1, OP_ADC, 32'd1, 32'd1, 4'd8, 1'b1, 1'b1);
      tick();
      check("b2b_first", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OP_OR, 32'(i), 32'h100, 4'(9 + i), 1'b1, 1'b1);
         tick();
         check("b2b_valid", {31'd0, out_valid}, 32'd1);
         if (i == 0) check("b2b_adc", out_result, 32'd2);
      end
      drive(1'b0, 8'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
      tick();
      check("b2b_valid4", {31'd0, out_valid}, 32'd1);
      tick();
      check("b2b_end", {31'd0, out_valid}, 32'd0);
      check("b2b_retire", {16'd0, retire_count}, 32'd4);

      // Asynchronous reset with both stages full.
      drive(1'b1, OP_ADD, 32'hFFFFFFFF, 32'd1, 4'd1, 1'b1, 1'b1);
      tick();
      idle(2);
      drive(1'b1, OP_NOT, 32'd0, 32'd0, 4'd2, 1'b1, 1'b0);
      tick();
      drive(1'b1, OP_SHL, 32'd1, 32'd4, 4'd3, 1'b1, 1'b0);
      tick();
      check("pre_rst_full", {31'd0, in_ready}, 32'd0);
      #2 resetn = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
      check("arst_retire", {16'd0, retire_count}, 32'd0);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 2000; i++) begin
         random_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
         tick();
      end
      quiesce();

      // Stream up to a retire count of 0xFFFF.
      while (int'(m_ret) + exp_q.size() < 65535) begin
         random_op(1'b1, 1'b1);
         tick();
      end
      quiesce();
      check("ret_ffff", {16'd0, retire_count}, 32'h0000FFFF);

      // Unsupported op without setflags, and counter wrap.
      sc = m_c; sz = m_z; sn = m_n;
      drive(1'b1, 8'hFF, 32'h12345678, 32'h9ABCDEF0, 4'd15, 1'b0, 1'b1);
      tick();
      idle(1);
      check("unsup_result", out_result, 32'd0);
      check("unsup_flags", {29'd0, flag_c, flag_z, flag_n}, {29'd0, sc, sz, sn});
      quiesce();
      check("ret_wrap", {16'd0, retire_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
